pwm_gen: RTL and testbench

- Downstream PWM generator for the steering motor.
- Consumes the ratio/update/enable request from the angle controller, and returns a one-cycle pwm_done pulse once the new ratio is actually in effect.
- Produces the single-ended PWM drive signal to the motor driver.
- Ratio changes are double-buffered and take effect only at a PWM period boundary, so there are no glitched periods.

---
 rtl/pwm_gen.sv | 165 ++++++++++++++++
 tb/tb_pwm_gen.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_gen.sv
// pwm_gen: double-buffered PWM generator for the steering motor.
// Optional PWM_RAMP_EN: slew active_ratio toward a target per period.
module pwm_gen #(
  parameter int CLK_DIV   = 4,
  parameter int RAMP_STEP = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pwm_enable,
  input  logic [7:0] pwm_ratio,
  input  logic       pwm_update,
  output logic       pwm_done,
  output logic       pwm_out,
  output logic       update_pending,
  output logic [7:0] active_ratio
);

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [7:0]  CNT_LAST = 8'd254;

  if (CLK_DIV < 1 || CLK_DIV > 65535) begin : g_div_chk
    $error("CLK_DIV out of range");
  end

  if (RAMP_STEP < 1 || RAMP_STEP > 255) begin : g_step_chk
    $error("RAMP_STEP out of range");
  end

  logic [15:0] prescaler;
  logic [7:0]  count;
  logic        tick;
  logic        boundary;
  logic        apply_win;
  logic        apply_req;

  assign tick      = (prescaler == DIV_LAST);
  assign boundary  = tick && (count == CNT_LAST);
  assign apply_win = !pwm_enable || boundary;
  assign apply_req = update_pending || pwm_update;

  // Prescaler: divides the clock down to counter ticks, held while disabled
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prescaler <= '0;
    end else if (!pwm_enable) begin
      prescaler <= '0;
    end else if (tick) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + 16'd1;
    end
  end

  // Period counter: 0..254 on ticks, restarts at 0 whenever disabled
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (!pwm_enable) begin
      count <= '0;
    end else if (tick) begin
      if (count == CNT_LAST) begin
        count <= '0;
      end else begin
        count <= count + 8'd1;
      end
    end
  end

  // Registered compare: ratio 0 never high, ratio 255 always high
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pwm_out <= 1'b0;
    end else begin
      pwm_out <= pwm_enable && (count < active_ratio);
    end
  end

`ifdef PWM_RAMP_EN

  localparam logic [7:0] STEP = 8'(RAMP_STEP);

  logic [7:0] target_ratio;
  logic [7:0] tgt_in;
  logic [7:0] ramp_val;
  logic [7:0] diff;

  assign tgt_in = pwm_update ? pwm_ratio : target_ratio;

  // Saturating one-period step toward the target, never overshooting
  always_comb begin
    diff     = '0;
    ramp_val = tgt_in;
    if (tgt_in > active_ratio) begin
      diff = tgt_in - active_ratio;
      if (diff > STEP) begin
        ramp_val = active_ratio + STEP;
      end
    end else if (tgt_in < active_ratio) begin
      diff = active_ratio - tgt_in;
      if (diff > STEP) begin
        ramp_val = active_ratio - STEP;
      end
    end
  end

  // Target capture and ramped apply; done only when the target is reached
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      target_ratio   <= '0;
      active_ratio   <= '0;
      update_pending <= 1'b0;
      pwm_done       <= 1'b0;
    end else begin
      pwm_done <= 1'b0;
      if (!pwm_enable && apply_req) begin
        target_ratio   <= tgt_in;
        active_ratio   <= tgt_in;
        update_pending <= 1'b0;
        pwm_done       <= 1'b1;
      end else if (boundary && apply_req) begin
        target_ratio <= tgt_in;
        active_ratio <= ramp_val;
        if (ramp_val == tgt_in) begin
          update_pending <= 1'b0;
          pwm_done       <= 1'b1;
        end else begin
          update_pending <= 1'b1;
        end
      end else if (pwm_update) begin
        target_ratio   <= pwm_ratio;
        update_pending <= 1'b1;
      end
    end
  end

`else

  logic [7:0] pending_ratio;
  logic [7:0] new_ratio;

  assign new_ratio = pwm_update ? pwm_ratio : pending_ratio;

  // Double buffer: capture any time, apply only at a boundary or when idle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending_ratio  <= '0;
      active_ratio   <= '0;
      update_pending <= 1'b0;
      pwm_done       <= 1'b0;
    end else begin
      pwm_done <= 1'b0;
      if (apply_win && apply_req) begin
        active_ratio   <= new_ratio;
        update_pending <= 1'b0;
        pwm_done       <= 1'b1;
      end else if (pwm_update) begin
        pending_ratio  <= pwm_ratio;
        update_pending <= 1'b1;
      end
    end
  end

`endif

endmodule

// File: tb/tb_pwm_gen.sv
// tb_pwm_gen: directed checks of pwm_gen with CLK_DIV=2
// (510-clock periods), ramp scenario when PWM_RAMP_EN is set.
module tb_pwm_gen;

  logic       clock = 1'b0;
  logic       reset;
  logic       pwm_enable;
  logic [7:0] pwm_ratio;
  logic       pwm_update;
  logic       pwm_done;
  logic       pwm_out;
  logic       update_pending;
  logic [7:0] active_ratio;

  int vectors = 0;
  int errors  = 0;

  always #5 clock = ~clock;

  pwm_gen #(
    .CLK_DIV  (2),
    .RAMP_STEP(8)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .pwm_enable    (pwm_enable),
    .pwm_ratio     (pwm_ratio),
    .pwm_update    (pwm_update),
    .pwm_done      (pwm_done),
    .pwm_out       (pwm_out),
    .update_pending(update_pending),
    .active_ratio  (active_ratio)
  );

  task automatic wait_done(input int budget, output int n);
    n = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clock);
      pwm_update = 1'b0;
      if (pwm_done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic measure(input int len, output int highs,
                         output int dones);
    highs = 0;
    dones = 0;
    for (int i = 0; i < len; i++) begin
      @(negedge clock);
      highs += int'(pwm_out);
      dones += int'(pwm_done);
    end
  endtask

  task automatic test_reset;
    int h, d;
    reset      = 1'b1;
    pwm_enable = 1'b0;
    pwm_update = 1'b0;
    pwm_ratio  = 8'd0;
    repeat (5) @(negedge clock);
    vectors++;
    if ({pwm_out, pwm_done, update_pending} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000",
               {pwm_out, pwm_done, update_pending});
    end
    vectors++;
    if (active_ratio !== 8'd0) begin
      errors++;
      $display("FAIL reset_ratio: got %0d expected 0", active_ratio);
    end
    reset      = 1'b0;
    pwm_enable = 1'b1;
    measure(1020, h, d);
    vectors++;
    if (h !== 0) begin
      errors++;
      $display("FAIL reset_idle_high: got %0d expected 0", h);
    end
    vectors++;
    if (d !== 0) begin
      errors++;
      $display("FAIL reset_idle_done: got %0d expected 0", d);
    end
  endtask

  task automatic test_basic_duty;
    int n, h, d;
    pwm_enable = 1'b0;
    @(negedge clock);
    pwm_enable = 1'b1;
    pwm_ratio  = 8'd64;
    pwm_update = 1'b1;
    wait_done(600, n);
    vectors++;
    if (n !== 510) begin
      errors++;
      $display("FAIL basic_done_latency: got %0d expected 510", n);
    end
    vectors++;
    if (active_ratio !== 8'd64) begin
      errors++;
      $display("FAIL basic_ratio: got %0d expected 64", active_ratio);
    end
    measure(510, h, d);
    vectors++;
    if (h !== 128 || d !== 0) begin
      errors++;
      $display("FAIL basic_period1: high %0d done %0d expected 128 0",
               h, d);
    end
    measure(510, h, d);
    vectors++;
    if (h !== 128) begin
      errors++;
      $display("FAIL basic_period2: got %0d expected 128", h);
    end
  endtask

  task automatic test_double_buffer;
    int h, d;
    h = 0;
    d = 0;
    for (int i = 1; i <= 510; i++) begin
      @(negedge clock);
      h += int'(pwm_out);
      d += int'(pwm_done);
      if (i == 20) begin
        pwm_ratio  = 8'd200;
        pwm_update = 1'b1;
      end
      if (i == 21) pwm_update = 1'b0;
      if (i == 100) begin
        vectors++;
        if (update_pending !== 1'b1 || active_ratio !== 8'd64) begin
          errors++;
          $display("FAIL dbuf_pending: pend %b ratio %0d expected 1 64",
                   update_pending, active_ratio);
        end
      end
    end
    vectors++;
    if (h !== 128 || d !== 1) begin
      errors++;
      $display("FAIL dbuf_cur_period: high %0d done %0d expected 128 1",
               h, d);
    end
    vectors++;
    if (active_ratio !== 8'd200 || update_pending !== 1'b0) begin
      errors++;
      $display("FAIL dbuf_applied: ratio %0d pend %b expected 200 0",
               active_ratio, update_pending);
    end
    measure(510, h, d);
    vectors++;
    if (h !== 400 || d !== 0) begin
      errors++;
      $display("FAIL dbuf_next_period: high %0d done %0d expected 400 0",
               h, d);
    end
  endtask

  task automatic test_extremes;
    int n, h, d;
    pwm_ratio  = 8'd0;
    pwm_update = 1'b1;
    wait_done(600, n);
    vectors++;
    if (n !== 510) begin
      errors++;
      $display("FAIL ext0_latency: got %0d expected 510", n);
    end
    measure(510, h, d);
    vectors++;
    if (h !== 0) begin
      errors++;
      $display("FAIL ext0_high: got %0d expected 0", h);
    end
    pwm_ratio  = 8'd255;
    pwm_update = 1'b1;
    wait_done(600, n);
    vectors++;
    if (n !== 510) begin
      errors++;
      $display("FAIL ext255_latency: got %0d expected 510", n);
    end
    measure(1020, h, d);
    vectors++;
    if (h !== 1020) begin
      errors++;
      $display("FAIL ext255_high: got %0d expected 1020", h);
    end
  endtask

  task automatic test_disabled;
    int h, d;
    pwm_enable = 1'b0;
    @(negedge clock);
    vectors++;
    if (pwm_out !== 1'b0) begin
      errors++;
      $display("FAIL dis_out_low: got %b expected 0", pwm_out);
    end
    pwm_ratio  = 8'd100;
    pwm_update = 1'b1;
    @(negedge clock);
    pwm_update = 1'b0;
    vectors++;
    if ({pwm_done, pwm_out} !== 2'b10 || active_ratio !== 8'd100) begin
      errors++;
      $display("FAIL dis_apply: done %b out %b ratio %0d expected 1 0 100",
               pwm_done, pwm_out, active_ratio);
    end
    @(negedge clock);
    vectors++;
    if (pwm_done !== 1'b0) begin
      errors++;
      $display("FAIL dis_single_pulse: got %b expected 0", pwm_done);
    end
    pwm_enable = 1'b1;
    measure(510, h, d);
    vectors++;
    if (h !== 200 || d !== 0) begin
      errors++;
      $display("FAIL dis_reenable: high %0d done %0d expected 200 0",
               h, d);
    end
  endtask

  task automatic test_reset_mid;
    int h, d;
    reset = 1'b1;
    @(negedge clock);
    reset      = 1'b0;
    pwm_enable = 1'b1;
    pwm_ratio  = 8'd50;
    pwm_update = 1'b1;
    @(negedge clock);
    pwm_update = 1'b0;
    vectors++;
    if (update_pending !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pending: got %b expected 1", update_pending);
    end
    repeat (20) @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    vectors++;
    if ({pwm_done, update_pending} !== 2'b00 || active_ratio !== 8'd0)
    begin
      errors++;
      $display("FAIL rst_mid_state: done %b pend %b ratio %0d expected 0",
               pwm_done, update_pending, active_ratio);
    end
    reset = 1'b0;
    measure(600, h, d);
    vectors++;
    if (d !== 0 || h !== 0 || active_ratio !== 8'd0) begin
      errors++;
      $display("FAIL rst_mid_discard: done %0d high %0d ratio %0d exp 0",
               d, h, active_ratio);
    end
  endtask

`ifdef PWM_RAMP_EN
  task automatic test_ramp;
    logic [7:0] prev;
    logic [7:0] exp_r [3];
    logic       exp_d [3];
    bit         seen;
    exp_r[0] = 8'd8;
    exp_r[1] = 8'd16;
    exp_r[2] = 8'd20;
    exp_d[0] = 1'b0;
    exp_d[1] = 1'b0;
    exp_d[2] = 1'b1;
    reset = 1'b1;
    @(negedge clock);
    reset      = 1'b0;
    pwm_enable = 1'b1;
    pwm_ratio  = 8'd20;
    pwm_update = 1'b1;
    prev       = 8'd0;
    for (int s = 0; s < 3; s++) begin
      seen = 1'b0;
      for (int i = 0; i < 600; i++) begin
        @(negedge clock);
        pwm_update = 1'b0;
        if (active_ratio !== prev) begin
          seen = 1'b1;
          break;
        end
      end
      vectors++;
      if (!seen || active_ratio !== exp_r[s] || pwm_done !== exp_d[s])
      begin
        errors++;
        $display("FAIL ramp_step%0d: ratio %0d done %b expected %0d %b",
                 s, active_ratio, pwm_done, exp_r[s], exp_d[s]);
      end
      prev = active_ratio;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_duty();
    test_double_buffer();
    test_extremes();
    test_disabled();
    test_reset_mid();
`ifdef PWM_RAMP_EN
    test_ramp();
`endif
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
